// File: rtl/display_pkg.sv
// Shared display definitions: glyph codes, segment constants and default
// scan timing used by the 7-segment drivers and the mode modules.
package display_pkg;

    // Glyph codes that do not map to a plain hex digit
    localparam logic [3:0] GLYPH_B     = 4'hA;
    localparam logic [3:0] GLYPH_S     = 4'hB;
    localparam logic [3:0] GLYPH_L     = 4'hC;
    localparam logic [3:0] GLYPH_D     = 4'hD;
    localparam logic [3:0] GLYPH_E     = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // All cathodes released (active-low) and all anodes disabled
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Default scan timing in clk cycles
    localparam int DEFAULT_REFRESH_DIV  = 100_000;
    localparam int DEFAULT_BLANK_CYCLES = 1_000;

    // Position of the current cycle within a digit slot
    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_ON    = 2'd1,
        PH_OFF   = 2'd2
    } slot_phase_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-code to active-low segment pattern {g,f,e,d,c,b,a}.
import display_pkg::*;

module seg7_glyph_decode (
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Lookup table; blank glyph releases every cathode
    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            4'h0:        o_seg = 7'h40;
            4'h1:        o_seg = 7'h79;
            4'h2:        o_seg = 7'h24;
            4'h3:        o_seg = 7'h30;
            4'h4:        o_seg = 7'h19;
            4'h5:        o_seg = 7'h12;
            4'h6:        o_seg = 7'h02;
            4'h7:        o_seg = 7'h78;
            4'h8:        o_seg = 7'h00;
            4'h9:        o_seg = 7'h10;
            GLYPH_B:     o_seg = 7'h03;
            GLYPH_S:     o_seg = 7'h12;
            GLYPH_L:     o_seg = 7'h47;
            GLYPH_D:     o_seg = 7'h21;
            GLYPH_E:     o_seg = 7'h06;
            GLYPH_BLANK: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with per-slot blanking, 8-level PWM
// brightness and frame-boundary input latching (no mid-frame tearing).
import display_pkg::*;

module seg7_scan_driver #(
    parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seg_data,
    input  logic [3:0]  dp_in,
    input  logic [2:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int             SW        = $clog2(REFRESH_DIV);
    localparam int             UNIT      = (REFRESH_DIV - BLANK_CYCLES) >> 3;
    localparam logic [SW-1:0]  SLOT_LAST = SW'(REFRESH_DIV - 1);

    logic [SW-1:0] r_slot_cnt;
    logic [1:0]    r_digit_idx;
    logic          r_first;
    logic [15:0]   r_shadow_data;
    logic [3:0]    r_shadow_dp;
    logic [2:0]    r_shadow_bright;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_slot_wrap;
    logic          w_latch;
    logic [31:0]   w_on_end;
    logic [31:0]   w_slot_ext;
    logic [3:0]    w_nibble;
    logic [6:0]    w_glyph_seg;
    logic [3:0]    w_an_on;
    slot_phase_e   w_phase;

    assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
    // Capture inputs once right after reset and then only at the 3->0 frame wrap
    assign w_latch     = r_first || (w_slot_wrap && (r_digit_idx == 2'd3));
    assign w_slot_ext  = 32'(r_slot_cnt);
    assign w_on_end    = 32'(BLANK_CYCLES) + 32'(UNIT) * (32'(r_shadow_bright) + 32'd1);
    assign w_nibble    = r_shadow_data[r_digit_idx*4 +: 4];
    assign w_an_on     = ~(4'b0001 << r_digit_idx);

    seg7_glyph_decode u_decode (
        .i_code (w_nibble),
        .o_seg  (w_glyph_seg)
    );

    // Slot counter and digit index; digit advances on every slot wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= 2'd0;
        end else if (w_slot_wrap) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_slot_cnt  <= r_slot_cnt + SW'(1);
        end
    end

    // Flags the first cycle after reset release so inputs are latched at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
        end
    end

    // Shadow registers hold the displayed frame constant until the next latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow_data   <= 16'hFFFF;
            r_shadow_dp     <= 4'h0;
            r_shadow_bright <= 3'd0;
        end else if (w_latch) begin
            r_shadow_data   <= seg_data;
            r_shadow_dp     <= dp_in;
            r_shadow_bright <= brightness;
        end
    end

    // Classify the current slot position into blank / on / off
    always_comb begin
        w_phase = PH_OFF;
        if (w_slot_ext < 32'(BLANK_CYCLES)) begin
            w_phase = PH_BLANK;
        end else if (w_slot_ext < w_on_end) begin
            w_phase = PH_ON;
        end
    end

    // Registered outputs; only the ON phase drives a single anode low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_phase == PH_ON) begin
            r_an  <= w_an_on;
            r_seg <= w_glyph_seg;
            r_dp  <= ~r_shadow_dp[r_digit_idx];
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=16, BLANK_CYCLES=2.
// Every cycle of each checked slot is compared as one {an,seg,dp} word.
module tb_seg7_scan_driver;

    localparam int RD = 16;
    localparam int BC = 2;
    localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] seg_data = 16'h1234;
    logic [3:0]  dp_in = 4'h0;
    logic [2:0]  brightness = 3'd7;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int compared = 0;
    int mismatched = 0;

    seg7_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_data   (seg_data),
        .dp_in      (dp_in),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // Hand-written decode table
    function automatic logic [6:0] exp_glyph(input logic [3:0] c);
        logic [6:0] r;
        case (c)
            4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
            4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
            4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h03;  4'hB: r = 7'h12;
            4'hC: r = 7'h47;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h7F;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed {an,seg,dp}=%h expected %h", tag, obs, exp_v);
        end
    endtask

    // One digit slot: blank for BC cycles, on for on_len cycles, then off
    task automatic run_slot(input int dig, input logic [6:0] sv, input logic dpv,
                            input int on_len, input string tag);
        logic [3:0]  an_exp;
        logic [11:0] exp_v;
        an_exp = ~(4'b0001 << dig);
        for (int s = 0; s < RD; s++) begin
            step();
            if (s >= BC && s < BC + on_len) exp_v = {an_exp, sv, dpv};
            else                            exp_v = DARK;
            check($sformatf("%s d%0d s%0d", tag, dig, s), {an, seg, dp}, exp_v);
        end
    endtask

    // One frame; the next inputs are applied after the digit-0 slot,
    // i.e. mid-frame, so they must only appear in the following frame
    task automatic run_frame(input logic [15:0] data, input logic [3:0] dpv, input int on_len,
                             input logic [15:0] nd, input logic [3:0] ndp, input logic [2:0] nb,
                             input string tag);
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) begin
            nib = data[d*4 +: 4];
            run_slot(d, exp_glyph(nib), ~dpv[d], on_len, tag);
            if (d == 0) begin
                seg_data   = nd;
                dp_in      = ndp;
                brightness = nb;
            end
        end
    endtask

    // At most one anode may be low in any cycle
    always @(negedge clk) begin
        compared++;
        assert ($countones(~an) <= 1) else begin
            mismatched++;
            $error("FAIL one_hot_an: observed an=%b expected at most one low bit", an);
        end
    end

    initial begin
        logic [15:0] nd;
        logic [3:0]  ndp;
        logic [2:0]  nb;

        repeat (3) step();
        check("reset_hold", {an, seg, dp}, DARK);
        reset = 1'b0;

        // brightness 7 -> ON_LEN = (14>>3)*8 = 8
        run_frame(16'h1234, 4'h0,    8, 16'h900D, 4'b0100, 3'd7, "f1234");
        run_frame(16'h900D, 4'b0100, 8, 16'h1111, 4'h0,    3'd7, "f900d");
        // 8888 and brightness 0 arrive while digit_idx=1: current frame unchanged
        run_frame(16'h1111, 4'h0,    8, 16'h8888, 4'h0,    3'd0, "f1111");
        run_frame(16'h8888, 4'h0,    1, 16'hFFF0, 4'b0001, 3'd3, "f8888");

        // Sweep every glyph code in digit 0, brightness 3 -> ON_LEN 4
        for (int c = 0; c < 16; c++) begin
            if (c < 15) begin
                nd = {12'hFFF, 4'(c + 1)}; ndp = 4'b0001; nb = 3'd3;
            end else begin
                nd = 16'h5678; ndp = 4'h0; nb = 3'd7;
            end
            run_frame({12'hFFF, 4'(c)}, 4'b0001, 4, nd, ndp, nb, $sformatf("sweep%0d", c));
        end

        // Reset asserted while digit 1 is lit
        run_slot(0, 7'h00, 1'b1, 8, "pre_rst");
        step(); check("pre_rst d1 s0", {an, seg, dp}, DARK);
        step(); check("pre_rst d1 s1", {an, seg, dp}, DARK);
        step(); check("pre_rst d1 s2", {an, seg, dp}, {4'b1101, 7'h78, 1'b1});
        reset = 1'b1;
        #1;
        check("rst_async", {an, seg, dp}, DARK);
        repeat (2) step();
        check("rst_held", {an, seg, dp}, DARK);
        reset = 1'b0;
        run_frame(16'h5678, 4'h0, 8, 16'h5678, 4'h0, 3'd7, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
